frame_scheduler: RTL and testbench

Frame-level scheduler for the feature extractor. It counts accepted audio samples and issues one `frame_start` per hop to launch the FFT/mel front end. It tracks per-frame feature beats leaving the ping-pong buffer towards the binarizer, and marks frame and keyword-window boundaries for the inference engine. It also detects frame overrun, i.e. a new frame launched before the previous frame's features have drained.

---
 rtl/frame_scheduler.sv | 204 ++++++++++++++++++++
 tb/tb_frame_scheduler.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : frame_scheduler
// Description : Frame-level scheduler for the feature extractor. Counts
//               accepted audio samples and issues one frame_start per hop
//               (after a first full window), tracks feature beats leaving the
//               ping-pong buffer, marks frame / keyword-window boundaries and
//               flags frame overrun.
// Ports       : clk, rst_n (async, active-low)
//               spi_en_inf_system_sync - inference enable, low = sync clear
//               sample_valid           - one audio sample accepted
//               feat_valid             - ping-pong buffer output beat
//               frame_start            - pulse, launch front end for a frame
//               frame_done             - pulse, N_MEL-th beat of a frame seen
//               window_done            - pulse, with last frame_done of window
//               frame_idx              - index of frame being received
//               overrun                - sticky overrun / spurious-beat flag
//               busy                   - high while filling or running
// Revision    : 1.0 - initial release
// ============================================================================
module frame_scheduler #(
    parameter int WIN_LEN = 512,
    parameter int HOP_LEN = 256,
    parameter int N_MEL   = 32,
    parameter int N_FRAME = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       spi_en_inf_system_sync,
    input  logic                       sample_valid,
    input  logic                       feat_valid,
    output logic                       frame_start,
    output logic                       frame_done,
    output logic                       window_done,
    output logic [$clog2(N_FRAME)-1:0] frame_idx,
    output logic                       overrun,
    output logic                       busy
);

    localparam int C_SAMP_MAX = (WIN_LEN > HOP_LEN) ? WIN_LEN : HOP_LEN;
    localparam int C_SAMP_W   = (C_SAMP_MAX > 1) ? $clog2(C_SAMP_MAX) : 1;
    localparam int C_BEAT_W   = (N_MEL > 1) ? $clog2(N_MEL) : 1;
    localparam int C_FIDX_W   = $clog2(N_FRAME);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [C_SAMP_W-1:0]   samp_cnt_q, samp_cnt_d;
    logic [C_BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [C_FIDX_W-1:0]   frame_idx_q, frame_idx_d;
    logic [1:0]            pend_q, pend_d;
    logic                  pad_pending_q, pad_pending_d;
    logic                  overrun_q, overrun_d;
    logic                  frame_start_q, frame_start_d;
    logic                  frame_done_q, frame_done_d;
    logic                  window_done_q, window_done_d;
    logic                  busy_q, busy_d;

    // The first launch after enable only primes the ping-pong buffer, so it
    // never produces output beats and must not be counted as outstanding.
    logic w_pad_start;
    logic w_real_start;
    assign w_pad_start  = frame_start_q &  pad_pending_q;
    assign w_real_start = frame_start_q & ~pad_pending_q;

    always_comb begin
        state_d       = state_q;
        samp_cnt_d    = samp_cnt_q;
        beat_cnt_d    = beat_cnt_q;
        frame_idx_d   = frame_idx_q;
        pend_d        = pend_q;
        pad_pending_d = pad_pending_q;
        overrun_d     = overrun_q;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        window_done_d = 1'b0;

        if (!spi_en_inf_system_sync) begin
            state_d       = S_IDLE;
            samp_cnt_d    = '0;
            beat_cnt_d    = '0;
            frame_idx_d   = '0;
            pend_d        = 2'd0;
            pad_pending_d = 1'b0;
            overrun_d     = 1'b0;
        end else begin
            // Sample pacing: one window before the first launch, then hops.
            case (state_q)
                S_IDLE: begin
                    state_d    = S_FILL;
                    samp_cnt_d = '0;
                end
                S_FILL: begin
                    if (sample_valid) begin
                        if (samp_cnt_q == C_SAMP_W'(WIN_LEN - 1)) begin
                            frame_start_d = 1'b1;
                            samp_cnt_d    = '0;
                            pad_pending_d = 1'b1;
                            state_d       = S_RUN;
                        end else begin
                            samp_cnt_d = samp_cnt_q + C_SAMP_W'(1);
                        end
                    end
                end
                S_RUN: begin
                    if (sample_valid) begin
                        if (samp_cnt_q == C_SAMP_W'(HOP_LEN - 1)) begin
                            frame_start_d = 1'b1;
                            samp_cnt_d    = '0;
                        end else begin
                            samp_cnt_d = samp_cnt_q + C_SAMP_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase

            if (state_q != S_IDLE) begin
                if (w_pad_start) begin
                    pad_pending_d = 1'b0;
                end

                // Outstanding-frame accounting works on the visible pulses,
                // so a launch and a completion in one cycle cancel out.
                if (w_real_start && !frame_done_q) begin
                    if (pend_q != 2'd0) begin
                        overrun_d = 1'b1;
                    end
                    if (pend_q != 2'd2) begin
                        pend_d = pend_q + 2'd1;
                    end
                end else if (frame_done_q && !w_real_start) begin
                    if (pend_q != 2'd0) begin
                        pend_d = pend_q - 2'd1;
                    end
                end

                if (feat_valid) begin
                    // A beat with nothing outstanding is spurious.
                    if (pend_q == 2'd0) begin
                        overrun_d = 1'b1;
                    end
                    if (beat_cnt_q == C_BEAT_W'(N_MEL - 1)) begin
                        beat_cnt_d   = '0;
                        frame_done_d = 1'b1;
                        if (frame_idx_q == C_FIDX_W'(N_FRAME - 1)) begin
                            frame_idx_d   = '0;
                            window_done_d = 1'b1;
                        end else begin
                            frame_idx_d = frame_idx_q + C_FIDX_W'(1);
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + C_BEAT_W'(1);
                    end
                end
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            samp_cnt_q    <= '0;
            beat_cnt_q    <= '0;
            frame_idx_q   <= '0;
            pend_q        <= 2'd0;
            pad_pending_q <= 1'b0;
            overrun_q     <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            window_done_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            samp_cnt_q    <= samp_cnt_d;
            beat_cnt_q    <= beat_cnt_d;
            frame_idx_q   <= frame_idx_d;
            pend_q        <= pend_d;
            pad_pending_q <= pad_pending_d;
            overrun_q     <= overrun_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            window_done_q <= window_done_d;
            busy_q        <= busy_d;
        end
    end

    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign window_done = window_done_q;
    assign frame_idx   = frame_idx_q;
    assign overrun     = overrun_q;
    assign busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_scheduler
// Description : Self-checking bench for frame_scheduler. A behavioural model
//               predicts outputs from running totals (samples and beats since
//               enable) and compares them every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_scheduler;

    localparam int WIN  = 8;
    localparam int HOP  = 4;
    localparam int NMEL = 4;
    localparam int NFR  = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       sv = 1'b0;
    logic       fv = 1'b0;
    logic       fs, fd, wd, ovr, busy;
    logic [1:0] idx;

    int checks = 0;
    int errors = 0;

    // model state: totals since the most recent enable
    int m_busy, m_n, m_b, m_starts, m_pend, m_ovr;
    int m_fs, m_fd, m_wd, m_idx;

    frame_scheduler #(
        .WIN_LEN (WIN),
        .HOP_LEN (HOP),
        .N_MEL   (NMEL),
        .N_FRAME (NFR)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .spi_en_inf_system_sync (en),
        .sample_valid           (sv),
        .feat_valid             (fv),
        .frame_start            (fs),
        .frame_done             (fd),
        .window_done            (wd),
        .frame_idx              (idx),
        .overrun                (ovr),
        .busy                   (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic model_reset();
        m_busy = 0; m_n = 0; m_b = 0; m_starts = 0; m_pend = 0; m_ovr = 0;
        m_fs = 0; m_fd = 0; m_wd = 0; m_idx = 0;
    endtask

    // Predicts the outputs visible after the current clock edge.
    task automatic model_edge();
        int real_start, nfs, nfd, nwd;
        if (!en) begin
            model_reset();
        end else if (m_busy == 0) begin
            model_reset();
            m_busy = 1;
        end else begin
            real_start = (m_fs != 0 && m_starts >= 2) ? 1 : 0;
            nfs = 0; nfd = 0; nwd = 0;
            if (sv) begin
                m_n++;
                if (m_n == WIN || (m_n > WIN && (m_n - WIN) % HOP == 0)) nfs = 1;
            end
            if (fv) begin
                if (m_pend == 0) m_ovr = 1;
                m_b++;
                if (m_b % NMEL == 0) begin
                    nfd   = 1;
                    m_idx = (m_b / NMEL) % NFR;
                    nwd   = (m_idx == 0) ? 1 : 0;
                end
            end
            if (real_start != 0 && m_fd == 0) begin
                if (m_pend >= 1) m_ovr = 1;
                if (m_pend < 2) m_pend++;
            end else if (m_fd != 0 && real_start == 0) begin
                if (m_pend > 0) m_pend--;
            end
            m_fs = nfs; m_fd = nfd; m_wd = nwd;
            if (nfs != 0) m_starts++;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("busy", busy, m_busy);
        chk("frame_start", fs, m_fs);
        chk("frame_done", fd, m_fd);
        chk("window_done", wd, m_wd);
        chk("frame_idx", idx, m_idx);
        chk("overrun", ovr, m_ovr);
        chk("pend", dut.pend_q, m_pend);
    endtask

    task automatic step(input logic e, input logic s, input logic f);
        en = e; sv = s; fv = f;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic hop();
        repeat (HOP) step(1'b1, 1'b1, 1'b0);
    endtask

    int seq_idx[$];
    int seq_wd[$];

    task automatic beats_rec(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0, 1'b1);
            if (fd) begin
                seq_idx.push_back(int'(idx));
                seq_wd.push_back(int'(wd));
            end
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0);

        // startup: one window then one hop
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < WIN; i++) begin
            step(1'b1, 1'b1, 1'b0);
            if (i < WIN - 1) chk("startup_no_fs", fs, 0);
        end
        chk("startup_fs", fs, 1);
        step(1'b1, 1'b0, 1'b0);
        chk("startup_fs_one_cycle", fs, 0);
        hop();
        chk("second_fs", fs, 1);
        step(1'b1, 1'b0, 1'b0);
        chk("second_pend", dut.pend_q, 1);
        chk("second_ovr", ovr, 0);

        // frame/window accounting
        beats_rec(NMEL);
        hop(); step(1'b1, 1'b0, 1'b0);
        beats_rec(NMEL);
        hop(); step(1'b1, 1'b0, 1'b0);
        beats_rec(NMEL);
        chk("fd_count", seq_idx.size(), 3);
        if (seq_idx.size() == 3) begin
            chk("idx_seq0", seq_idx[0], 1);
            chk("idx_seq1", seq_idx[1], 2);
            chk("idx_seq2", seq_idx[2], 0);
            chk("wd_seq0", seq_wd[0], 0);
            chk("wd_seq1", seq_wd[1], 0);
            chk("wd_seq2", seq_wd[2], 1);
        end
        step(1'b1, 1'b0, 1'b0);
        chk("acct_ovr", ovr, 0);

        // simultaneous frame_done and frame_start
        hop(); step(1'b1, 1'b0, 1'b0);
        repeat (NMEL - 1) step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        chk("simul_fs", fs, 1);
        chk("simul_fd", fd, 1);
        step(1'b1, 1'b0, 1'b0);
        chk("simul_pend", dut.pend_q, 1);
        chk("simul_ovr", ovr, 0);
        repeat (NMEL) step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);

        // overrun: two launches with no beats between
        hop(); step(1'b1, 1'b0, 1'b0);
        hop();
        chk("ovr_before", ovr, 0);
        step(1'b1, 1'b0, 1'b0);
        chk("ovr_set", ovr, 1);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 1'b0);
            chk("ovr_sticky", ovr, 1);
        end

        // disable mid-run after two beats
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk("dis_busy", busy, 0);
        chk("dis_idx", idx, 0);
        chk("dis_ovr", ovr, 0);
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < WIN; i++) begin
            step(1'b1, 1'b1, 1'b0);
            if (i < WIN - 1) chk("reen_no_fs", fs, 0);
        end
        chk("reen_fs", fs, 1);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(99) != 0) ? 1'b1 : 1'b0,
                 1'($urandom_range(1)),
                 ($urandom_range(3) == 0) ? 1'b1 : 1'b0);
        end

        // asynchronous reset mid-FILL with a sample in flight
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        repeat (5) step(1'b1, 1'b1, 1'b0);
        en = 1'b1; sv = 1'b1; fv = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_fs", fs, 0);
        chk("arst_fd", fd, 0);
        chk("arst_wd", wd, 0);
        chk("arst_idx", idx, 0);
        chk("arst_ovr", ovr, 0);
        model_reset();
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
        fv = 1'b0;
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < WIN; i++) begin
            step(1'b1, 1'b1, 1'b0);
            if (i < WIN - 1) chk("arst_no_fs", fs, 0);
        end
        chk("arst_fs_after", fs, 1);

        // asynchronous reset while a frame_start pulse is visible
        #1 rst_n = 1'b0;
        #1;
        chk("arst2_fs", fs, 0);
        chk("arst2_busy", busy, 0);
        model_reset();
        en = 1'b0; sv = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step(1'b0, 1'b1, 1'b0);
        chk("arst2_no_fs", fs, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
